// File: rtl/regex_pkg.sv
// Shared types and constants for the regex matcher stimulus path.
package regex_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned POS_W  = 32;

    // Matchers report this when they have no position to give.
    localparam logic [POS_W-1:0] NO_POS = '1;

    typedef enum logic [2:0] {
        StIdle,
        StMrst,
        StStream,
        StEnd,
        StDone
    } state_e;

endpackage

// File: rtl/regex_stream_feeder_if.sv
// Character-stream link between the feeder (master) and a regex matcher (slave).
interface regex_stream_feeder_if #(
    parameter int unsigned DATA_W = regex_pkg::DATA_W,
    parameter int unsigned POS_W  = regex_pkg::POS_W
);

    logic              m_reset;
    logic [DATA_W-1:0] data;
    logic              stream_end;
    logic              m_match;
    logic [POS_W-1:0]  m_start_pos;
    logic [POS_W-1:0]  m_end_pos;

    modport master (
        output m_reset, data, stream_end,
        input  m_match, m_start_pos, m_end_pos
    );

    modport slave (
        input  m_reset, data, stream_end,
        output m_match, m_start_pos, m_end_pos
    );

endinterface

// File: rtl/regex_char_buf.sv
// Character buffer: synchronous write, registered read that returns zero when not enabled.
module regex_char_buf #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = regex_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/regex_stream_feeder.sv
// Loads a string, replays it one char per clock into a regex matcher and latches the
// first match the matcher reports.
module regex_stream_feeder #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = regex_pkg::DATA_W,
    parameter int unsigned POS_W      = regex_pkg::POS_W,
    parameter int unsigned END_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_full,
    output logic [ADDR_W:0]     len,
    input  logic                start,
    input  logic                clr,
    output logic                busy,
    regex_stream_feeder_if.master mif,
    output logic                done,
    output logic                result_match,
    output logic [POS_W-1:0]    result_start,
    output logic [POS_W-1:0]    result_end
);

    import regex_pkg::*;

    localparam int unsigned    EndW    = (END_CYCLES > 1) ? $clog2(END_CYCLES) : 1;
    localparam logic [EndW-1:0] EndLast = EndW'(END_CYCLES - 1);
    localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [EndW-1:0]   end_cnt_q, end_cnt_d;
    logic              m_reset_q, m_reset_d;
    logic              stream_end_q, stream_end_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_full_q, wr_full_d;
    logic              res_match_q, res_match_d;
    logic [POS_W-1:0]  res_start_q, res_start_d;
    logic [POS_W-1:0]  res_end_q, res_end_d;
    logic              buf_we, buf_re;
    logic [ADDR_W-1:0] shown_idx;
    logic [ADDR_W:0]   last_idx;

    // rd_ptr runs one ahead of the char on data, so the char on display is rd_ptr-1.
    assign shown_idx = rd_ptr_q - 1'b1;
    assign last_idx  = count_q - 1'b1;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        end_cnt_d    = end_cnt_q;
        m_reset_d    = 1'b0;
        stream_end_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        res_match_d  = res_match_q;
        res_start_d  = res_start_q;
        res_end_d    = res_end_q;
        buf_we       = 1'b0;
        buf_re       = 1'b0;

        if ((state_q == StStream || state_q == StEnd) && mif.m_match && !res_match_q) begin
            res_match_d = 1'b1;
            res_start_d = mif.m_start_pos;
            res_end_d   = mif.m_end_pos;
        end

        unique case (state_q)
            StIdle, StDone: begin
                done_d = (state_q == StDone);
                if (clr) begin
                    state_d     = StIdle;
                    count_d     = '0;
                    done_d      = 1'b0;
                    res_match_d = 1'b0;
                    res_start_d = '0;
                    res_end_d   = '0;
                end else if (start) begin
                    res_match_d = 1'b0;
                    res_start_d = '0;
                    res_end_d   = '0;
                    if (count_q == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = StMrst;
                        done_d    = 1'b0;
                        m_reset_d = 1'b1;
                        busy_d    = 1'b1;
                        rd_ptr_d  = '0;
                    end
                end else if (wr_en && state_q == StIdle && count_q != FullCnt) begin
                    buf_we  = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            StMrst: begin
                state_d  = StStream;
                busy_d   = 1'b1;
                buf_re   = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            StStream: begin
                busy_d = 1'b1;
                if (shown_idx == last_idx[ADDR_W-1:0]) begin
                    state_d      = StEnd;
                    stream_end_d = 1'b1;
                    end_cnt_d    = '0;
                end else begin
                    buf_re   = 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            StEnd: begin
                if (end_cnt_q == EndLast) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    busy_d       = 1'b1;
                    stream_end_d = 1'b1;
                    end_cnt_d    = end_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        wr_full_d = (count_d == FullCnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            end_cnt_q    <= '0;
            m_reset_q    <= 1'b0;
            stream_end_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_full_q    <= 1'b0;
            res_match_q  <= 1'b0;
            res_start_q  <= '0;
            res_end_q    <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            end_cnt_q    <= end_cnt_d;
            m_reset_q    <= m_reset_d;
            stream_end_q <= stream_end_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wr_full_q    <= wr_full_d;
            res_match_q  <= res_match_d;
            res_start_q  <= res_start_d;
            res_end_q    <= res_end_d;
        end
    end

    regex_char_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_char_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_we),
        .wr_addr (count_q[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (buf_re),
        .rd_addr (rd_ptr_q),
        .rd_data (mif.data)
    );

    assign mif.m_reset    = m_reset_q;
    assign mif.stream_end = stream_end_q;
    assign wr_full        = wr_full_q;
    assign len            = count_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result_match   = res_match_q;
    assign result_start   = res_start_q;
    assign result_end     = res_end_q;

endmodule

// File: tb/tb_regex_stream_feeder.sv
// Randomized bench for regex_stream_feeder against a cycle-timeline model of a run.
module tb_regex_stream_feeder;

    localparam int unsigned DEPTH      = 64;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned POS_W      = 32;
    localparam int unsigned END_CYCLES = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_full;
    logic [ADDR_W:0]   len;
    logic              start;
    logic              clr;
    logic              busy;
    logic              done;
    logic              result_match;
    logic [POS_W-1:0]  result_start;
    logic [POS_W-1:0]  result_end;

    regex_stream_feeder_if #(.DATA_W(DATA_W), .POS_W(POS_W)) mif ();

    regex_stream_feeder #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .POS_W      (POS_W),
        .END_CYCLES (END_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_full      (wr_full),
        .len          (len),
        .start        (start),
        .clr          (clr),
        .busy         (busy),
        .mif          (mif),
        .done         (done),
        .result_match (result_match),
        .result_start (result_start),
        .result_end   (result_end)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;
    logic [7:0]  model_q[$];
    logic        exp_match;
    logic [31:0] exp_start;
    logic [31:0] exp_end;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic mr, input logic se, input logic bz,
                                         input logic dn, input logic rm, input logic wf,
                                         input logic [7:0] dt);
        return {50'd0, mr, se, bz, dn, rm, wf, dt};
    endfunction

    function automatic logic [63:0] obs();
        return pack(mif.m_reset, mif.stream_end, busy, done, result_match, wr_full, mif.data);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_char(input logic [7:0] ch);
        wr_en   = 1'b1;
        wr_data = ch;
        tick();
        wr_en   = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(ch);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model_q.delete();
    endtask

    // Start a run and compare every output cycle by cycle against the expected timeline:
    // m_reset in cycle 1, chars in 2..c+1, stream_end in c+2..c+1+END_CYCLES, done after.
    task automatic do_run(input string tag, input int pc0, input logic [31:0] s0,
                          input logic [31:0] e0, input int pc1, input logic [31:0] s1,
                          input logic [31:0] e1, input bit poke);
        int         c;
        int         last;
        logic       wf;
        logic [7:0] ed;
        c    = model_q.size();
        last = (c == 0) ? 1 : c + 2 + int'(END_CYCLES);
        wf   = (c == int'(DEPTH));
        exp_match = 1'b0;
        exp_start = '0;
        exp_end   = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= last; k++) begin
            ed = (c > 0 && k >= 2 && k <= c + 1) ? model_q[k-2] : 8'h00;
            check_eq({tag, ":cyc"}, obs(),
                     pack(c > 0 && k == 1, c > 0 && k >= c + 2 && k <= c + 1 + int'(END_CYCLES),
                          k < last, k == last, exp_match, wf, ed));
            if (k == last) break;
            mif.m_match     = (k == pc0) || (k == pc1);
            mif.m_start_pos = (k == pc0) ? s0 : s1;
            mif.m_end_pos   = (k == pc0) ? e0 : e1;
            if (mif.m_match && !exp_match && k >= 2 && k <= c + 1 + int'(END_CYCLES)) begin
                exp_match = 1'b1;
                exp_start = mif.m_start_pos;
                exp_end   = mif.m_end_pos;
            end
            start   = poke && k == 3;
            clr     = poke && k == 4;
            wr_en   = poke && k == 2;
            wr_data = 8'hA5;
            tick();
            mif.m_match = 1'b0;
            start = 1'b0;
            clr   = 1'b0;
            wr_en = 1'b0;
        end
        check_eq({tag, ":rstart"}, 64'(result_start), 64'(exp_start));
        check_eq({tag, ":rend"}, 64'(result_end), 64'(exp_end));
        check_eq({tag, ":len"}, 64'(len), 64'(c));
    endtask

    task automatic rand_run(input string tag, input bit poke);
        int c;
        int hi;
        c  = model_q.size();
        hi = c + 3 + int'(END_CYCLES);
        do_run(tag, int'($urandom_range(0, hi)), $urandom(), $urandom(),
               int'($urandom_range(0, hi)), $urandom(), $urandom(), poke);
    endtask

    initial begin
        string s;
        int    n;
        reset = 1'b1;
        wr_en = 1'b0;
        wr_data = '0;
        start = 1'b0;
        clr = 1'b0;
        mif.m_match = 1'b0;
        mif.m_start_pos = '0;
        mif.m_end_pos = '0;
        repeat (3) tick();
        reset = 1'b0;
        check_eq("reset_outs", obs(), pack(0, 0, 0, 0, 0, 0, 8'h00));
        check_eq("reset_len", 64'(len), 64'd0);
        check_eq("reset_res", {result_start, result_end}, 64'd0);

        // Directed: "testxabab", match reported after the last char.
        s = "testxabab";
        for (int i = 0; i < s.len(); i++) load_char(s[i]);
        check_eq("txt_len", 64'(len), 64'd9);
        do_run("txt", 10, 32'd0, 32'd8, 0, 32'd0, 32'd0, 1'b0);
        check_eq("txt_match", 64'(result_match), 64'd1);

        // Writes in DONE are dropped; DONE start replays identically, with busy-time pokes.
        wr_en = 1'b1;
        wr_data = 8'h41;
        tick();
        wr_en = 1'b0;
        check_eq("done_wr_len", 64'(len), 64'd9);
        do_run("rerun", 6, 32'd1, 32'd2, 9, 32'd3, 32'd4, 1'b1);

        // Empty buffer: straight to DONE with no match.
        do_clr();
        check_eq("clr_outs", obs(), pack(0, 0, 0, 0, 0, 0, 8'h00));
        do_run("empty", 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1'b0);

        // Fill to capacity; 65th write dropped.
        do_clr();
        for (int i = 0; i < 65; i++) begin
            load_char(8'($urandom_range(32, 126)));
            if (i == 62) check_eq("full_at63", 64'(wr_full), 64'd0);
            if (i == 63) check_eq("full_at64", 64'(wr_full), 64'd1);
        end
        check_eq("full_len", 64'(len), 64'd64);
        do_run("full2m", 5, 32'd3, 32'd7, 12, 32'd10, 32'd15, 1'b0);

        // Randomized runs and replays.
        for (int it = 0; it < 8; it++) begin
            do_clr();
            n = (it == 5) ? 64 : int'($urandom_range(0, 24));
            for (int i = 0; i < n; i++) load_char(8'($urandom()));
            rand_run("rnd", it[0]);
            rand_run("rnd_rerun", 1'b0);
        end

        // clr beats start in DONE.
        clr = 1'b1;
        start = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b0;
        model_q.delete();
        check_eq("clr_start", obs(), pack(0, 0, 0, 0, 0, 0, 8'h00));
        check_eq("clr_start_len", 64'(len), 64'd0);

        // Reset in the 4th STREAM cycle after a match was captured.
        for (int i = 0; i < 10; i++) load_char(8'($urandom_range(97, 122)));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        mif.m_match = 1'b1;
        mif.m_start_pos = 32'h55;
        mif.m_end_pos = 32'h66;
        tick();
        mif.m_match = 1'b0;
        tick();
        tick();
        check_eq("pre_rst", obs(), pack(0, 0, 1, 0, 1, 0, model_q[3]));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_q.delete();
        check_eq("mid_rst_outs", obs(), pack(0, 0, 0, 0, 0, 0, 8'h00));
        check_eq("mid_rst_len", 64'(len), 64'd0);
        check_eq("mid_rst_res", {result_start, result_end}, 64'd0);
        do_run("post_rst", 0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
